// File: rtl/vxe_cu_mvpu_fwd_unit_pkg.sv
// Shared VxE control-unit command field widths and VPU opcode encodings.
// Imported by the forwarding unit and its per-channel FIFO.
package vxe_cu_mvpu_fwd_unit_pkg;

    localparam int VXE_CU_OP_W = 5;
    localparam int VXE_CU_TH_W = 3;
    localparam int VXE_CU_PL_W = 48;

    typedef enum logic [VXE_CU_OP_W-1:0] {
        VPU_OP_NOP    = 5'd0,
        VPU_OP_LOAD   = 5'd1,
        VPU_OP_STORE  = 5'd2,
        VPU_OP_MAC    = 5'd3,
        VPU_OP_ADD    = 5'd4,
        VPU_OP_MUL    = 5'd5,
        VPU_OP_ACT    = 5'd6,
        VPU_OP_BCAST  = 5'd7,
        VPU_OP_SYNC   = 5'd8,
        VPU_OP_CFG    = 5'd9
    } vpu_op_e;

endpackage

// File: rtl/vxe_cu_fwd_fifo.sv
// Per-channel command FIFO, 2**DEPTH_POW2 entries, head read straight from storage registers.
// Latency: a push becomes visible at the head one edge later; no empty-FIFO bypass.
// Backpressure: push is ignored when full, pop ignored when empty; full drops the edge after a pop.
module vxe_cu_fwd_fifo
    import vxe_cu_mvpu_fwd_unit_pkg::*;
#(
    parameter int WIDTH      = VXE_CU_OP_W + VXE_CU_TH_W + VXE_CU_PL_W,
    parameter int DEPTH_POW2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_POW2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_POW2;
    localparam int AW    = DEPTH_POW2;
    localparam int CW    = DEPTH_POW2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_en;
    logic             pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/vxe_cu_mvpu_fwd_unit.sv
// Multi-channel VPU command forwarder: masks one CU command into any subset of per-VPU FIFOs.
// Latency: 1 cycle from accepted write to sel on each destination channel.
// Backpressure: rdy is low whenever any channel FIFO is full, so broadcasts never split.
module vxe_cu_mvpu_fwd_unit
    import vxe_cu_mvpu_fwd_unit_pkg::*;
#(
    parameter int NVPU       = 2,
    parameter int DEPTH_POW2 = 2,
    parameter int OP_W       = VXE_CU_OP_W,
    parameter int TH_W       = VXE_CU_TH_W,
    parameter int PL_W       = VXE_CU_PL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 o_fwd_vpu_rdy,
    input  logic [OP_W-1:0]      i_fwd_vpu_op,
    input  logic [TH_W-1:0]      i_fwd_vpu_th,
    input  logic [PL_W-1:0]      i_fwd_vpu_pl,
    input  logic [NVPU-1:0]      i_fwd_vpu_dst,
    input  logic                 i_fwd_vpu_wr,
    output logic [NVPU-1:0]      o_vpu_cmd_sel,
    input  logic [NVPU-1:0]      i_vpu_cmd_ack,
    output logic [NVPU*OP_W-1:0] o_vpu_cmd_op,
    output logic [NVPU*TH_W-1:0] o_vpu_cmd_th,
    output logic [NVPU*PL_W-1:0] o_vpu_cmd_pl,
    output logic [NVPU-1:0]      o_vpu_busy,
    output logic                 o_pipes_active
);

    localparam int W = OP_W + TH_W + PL_W;

    logic [NVPU-1:0] ch_full;
    logic [NVPU-1:0] ch_empty;
    logic [W-1:0]    wr_data;
    logic            accept;

    // Readiness depends only on FIFO state, never on the incoming mask or strobe.
    assign o_fwd_vpu_rdy = ~|ch_full;
    assign accept        = i_fwd_vpu_wr & o_fwd_vpu_rdy;
    assign wr_data       = {i_fwd_vpu_op, i_fwd_vpu_th, i_fwd_vpu_pl};

    for (genvar k = 0; k < NVPU; k++) begin : g_ch
        logic [W-1:0]          head;
        logic [DEPTH_POW2:0]   count;

        vxe_cu_fwd_fifo #(
            .WIDTH      (W),
            .DEPTH_POW2 (DEPTH_POW2)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (accept & i_fwd_vpu_dst[k]),
            .data  (wr_data),
            .pop   (i_vpu_cmd_ack[k]),
            .head  (head),
            .empty (ch_empty[k]),
            .full  (ch_full[k]),
            .count (count)
        );

        assign o_vpu_cmd_sel[k]               = ~ch_empty[k];
        assign o_vpu_busy[k]                  = |count;
        assign o_vpu_cmd_op[k*OP_W +: OP_W]   = head[W-1 -: OP_W];
        assign o_vpu_cmd_th[k*TH_W +: TH_W]   = head[PL_W +: TH_W];
        assign o_vpu_cmd_pl[k*PL_W +: PL_W]   = head[PL_W-1:0];
    end

    assign o_pipes_active = |o_vpu_busy;

endmodule

// File: tb/tb_vxe_cu_mvpu_fwd_unit.sv
// Randomized scoreboard bench for the forwarding unit: per-channel expected-command queues,
// filled by the driver on accept and drained by a negedge monitor on sel&ack.
module tb_vxe_cu_mvpu_fwd_unit;

    localparam int NVPU  = 2;
    localparam int DP    = 2;
    localparam int DEPTH = 4;
    localparam int OP_W  = 5;
    localparam int TH_W  = 3;
    localparam int PL_W  = 48;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [TH_W-1:0] th;
        logic [PL_W-1:0] pl;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 o_fwd_vpu_rdy;
    logic [OP_W-1:0]      i_fwd_vpu_op;
    logic [TH_W-1:0]      i_fwd_vpu_th;
    logic [PL_W-1:0]      i_fwd_vpu_pl;
    logic [NVPU-1:0]      i_fwd_vpu_dst;
    logic                 i_fwd_vpu_wr;
    logic [NVPU-1:0]      o_vpu_cmd_sel;
    logic [NVPU-1:0]      i_vpu_cmd_ack;
    logic [NVPU*OP_W-1:0] o_vpu_cmd_op;
    logic [NVPU*TH_W-1:0] o_vpu_cmd_th;
    logic [NVPU*PL_W-1:0] o_vpu_cmd_pl;
    logic [NVPU-1:0]      o_vpu_busy;
    logic                 o_pipes_active;

    vxe_cu_mvpu_fwd_unit #(
        .NVPU(NVPU), .DEPTH_POW2(DP), .OP_W(OP_W), .TH_W(TH_W), .PL_W(PL_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .o_fwd_vpu_rdy  (o_fwd_vpu_rdy),
        .i_fwd_vpu_op   (i_fwd_vpu_op),
        .i_fwd_vpu_th   (i_fwd_vpu_th),
        .i_fwd_vpu_pl   (i_fwd_vpu_pl),
        .i_fwd_vpu_dst  (i_fwd_vpu_dst),
        .i_fwd_vpu_wr   (i_fwd_vpu_wr),
        .o_vpu_cmd_sel  (o_vpu_cmd_sel),
        .i_vpu_cmd_ack  (i_vpu_cmd_ack),
        .o_vpu_cmd_op   (o_vpu_cmd_op),
        .o_vpu_cmd_th   (o_vpu_cmd_th),
        .o_vpu_cmd_pl   (o_vpu_cmd_pl),
        .o_vpu_busy     (o_vpu_busy),
        .o_pipes_active (o_pipes_active)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    cmd_t            exp_q [NVPU][$];
    bit              mon_en      = 1'b0;
    bit              acc_pending = 1'b0;
    bit              hold        = 1'b0;
    cmd_t            acc_cmd;
    logic [NVPU-1:0] acc_dst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        bit r = 1'b1;
        for (int k = 0; k < NVPU; k++) begin
            if (exp_q[k].size() >= DEPTH) r = 1'b0;
        end
        return r;
    endfunction

    // Monitor: compare what the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            bit   any_busy;
            cmd_t got;
            any_busy = 1'b0;
            check("rdy", 64'(o_fwd_vpu_rdy), 64'(model_rdy()));
            for (int k = 0; k < NVPU; k++) begin
                check($sformatf("sel%0d", k), 64'(o_vpu_cmd_sel[k]), 64'(exp_q[k].size() != 0));
                check($sformatf("busy%0d", k), 64'(o_vpu_busy[k]), 64'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    any_busy = 1'b1;
                    got.op = o_vpu_cmd_op[k*OP_W +: OP_W];
                    got.th = o_vpu_cmd_th[k*TH_W +: TH_W];
                    got.pl = o_vpu_cmd_pl[k*PL_W +: PL_W];
                    check($sformatf("head%0d", k), 64'(got), 64'(exp_q[k][0]));
                    if (i_vpu_cmd_ack[k]) void'(exp_q[k].pop_front());
                end
            end
            check("pipes_active", 64'(o_pipes_active), 64'(any_busy));
        end
    end

    // One driver cycle: commit last edge's accept into the model, then drive new inputs.
    task automatic step(input int wr_pct, input int ack_pct, input int dst_fix);
        @(posedge clk);
        #1;
        if (acc_pending) begin
            for (int k = 0; k < NVPU; k++) begin
                if (acc_dst[k]) exp_q[k].push_back(acc_cmd);
            end
            acc_pending = 1'b0;
        end
        if (!hold) begin
            i_fwd_vpu_wr  = ($urandom_range(99) < wr_pct);
            i_fwd_vpu_dst = (dst_fix < 0) ? NVPU'($urandom_range(3)) : NVPU'(dst_fix);
            i_fwd_vpu_op  = OP_W'($urandom);
            i_fwd_vpu_th  = TH_W'($urandom);
            i_fwd_vpu_pl  = {16'($urandom), 32'($urandom)};
        end
        if (i_fwd_vpu_wr && model_rdy()) begin
            acc_pending = 1'b1;
            acc_cmd     = '{op: i_fwd_vpu_op, th: i_fwd_vpu_th, pl: i_fwd_vpu_pl};
            acc_dst     = i_fwd_vpu_dst;
            hold        = 1'b0;
        end else begin
            hold = i_fwd_vpu_wr;
        end
        for (int k = 0; k < NVPU; k++) begin
            i_vpu_cmd_ack[k] = ($urandom_range(99) < ack_pct);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   64'(o_fwd_vpu_rdy),  64'd1);
        check({tag, "_sel"},   64'(o_vpu_cmd_sel),  64'd0);
        check({tag, "_busy"},  64'(o_vpu_busy),     64'd0);
        check({tag, "_pipes"}, 64'(o_pipes_active), 64'd0);
    endtask

    int wr_tab  [6] = '{100, 90, 50, 100, 30, 70};
    int ack_tab [6] = '{100, 10, 50, 60, 90, 0};

    initial begin
        rst           = 1'b1;
        i_fwd_vpu_wr  = 1'b0;
        i_fwd_vpu_dst = '0;
        i_fwd_vpu_op  = '0;
        i_fwd_vpu_th  = '0;
        i_fwd_vpu_pl  = '0;
        i_vpu_cmd_ack = '0;
        #12;
        check_reset_outputs("reset");
        check("reset_op", 64'(o_vpu_cmd_op), 64'd0);
        check("reset_pl0", 64'(o_vpu_cmd_pl[PL_W-1:0]), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single-channel stream with ack held high.
        for (int i = 0; i < 8; i++) step(100, 100, 1);
        // Skew stall: fill ch1 with no acks, then offer a ch0-only write.
        for (int i = 0; i < 6; i++) step(100, 0, 2);
        for (int i = 0; i < 4; i++) step(100, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 100, -1);
        // Null mask: accepted and dropped.
        for (int i = 0; i < 4; i++) step(100, 0, 0);
        // Broadcast against a stalled channel.
        for (int i = 0; i < 6; i++) step(100, 30, 3);

        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 300; i++) step(wr_tab[ph], ack_tab[ph], -1);
        end

        // Queue three commands on ch0, then reset mid-operation.
        for (int i = 0; i < 12; i++) step(0, 100, -1);
        for (int i = 0; i < 3; i++) step(100, 0, 1);
        step(0, 0, 1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("pre_reset_busy0", 64'(o_vpu_busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        for (int k = 0; k < NVPU; k++) exp_q[k].delete();
        acc_pending   = 1'b0;
        hold          = 1'b0;
        i_fwd_vpu_wr  = 1'b0;
        i_vpu_cmd_ack = '0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) step(100, 40, -1);
        for (int i = 0; i < 200; i++) step(60, 60, -1);

        // Final drain.
        for (int i = 0; i < 20; i++) step(0, 100, -1);
        @(negedge clk);
        check("drain_pipes", 64'(o_pipes_active), 64'd0);
        check("drain_rdy", 64'(o_fwd_vpu_rdy), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
